// File: rtl/gmii_rx_frame.sv
// GMII receive frame decoder: strips preamble/SFD, forwards frame bytes with
// start/end markers and reports FCS status, length and error flags per frame.
module gmii_rx_frame #(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_crc_ok,
  output logic        rx_err,
  output logic [10:0] rx_len,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] LEN_SAT     = 11'd2047;
  localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  state_t      state;
  logic        dv_reg, er_reg;
  logic [7:0]  rxd_reg;
  logic [2:0]  pre_cnt;
  logic [7:0]  hold;
  logic        hold_vld;
  logic        first_byte;
  logic        sticky_err;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic        crc_match;

  // NOTE: blocking assignments are correct here because c is a local temporary
  // of a combinational function; every stored register below uses <=.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] d);
    logic [31:0] c;
    c = crc_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  assign crc_match = (crc == CRC_RESIDUE);

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      dv_reg  <= 1'b0;
      er_reg  <= 1'b0;
      rxd_reg <= 8'h00;
    end else begin
      dv_reg  <= gmii_rx_dv;
      er_reg  <= gmii_rx_er;
      rxd_reg <= gmii_rxd;
    end
  end

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pre_cnt    <= 3'd0;
      hold       <= 8'h00;
      hold_vld   <= 1'b0;
      first_byte <= 1'b0;
      sticky_err <= 1'b0;
      byte_cnt   <= 11'd0;
      crc        <= CRC_INIT;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_crc_ok  <= 1'b0;
      rx_err     <= 1'b0;
      rx_len     <= 11'd0;
      frame_cnt  <= 16'd0;
      err_cnt    <= 16'd0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;

      // Statistics trail the registered end-of-frame beat by one cycle.
      if (rx_valid && rx_eof) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (rx_err) err_cnt <= err_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (dv_reg) begin
            if (rxd_reg == PRE_BYTE) begin
              state   <= PRE;
              pre_cnt <= 3'd1;
            end else begin
              state <= DROP;
            end
          end
        end

        PRE: begin
          if (!dv_reg) begin
            state <= IDLE;
          end else if (er_reg) begin
            state <= DROP;
          end else if (rxd_reg == SFD_BYTE) begin
            state      <= DATA;
            crc        <= CRC_INIT;
            byte_cnt   <= 11'd0;
            sticky_err <= 1'b0;
            hold_vld   <= 1'b0;
            first_byte <= 1'b1;
          end else if (rxd_reg == PRE_BYTE && pre_cnt != 3'd7) begin
            pre_cnt <= pre_cnt + 3'd1;
          end else begin
            state <= DROP;
          end
        end

        DATA: begin
          if (dv_reg) begin
            // The held byte leaves only once its successor proves it is not the last.
            if (hold_vld) begin
              rx_valid   <= 1'b1;
              rx_data    <= hold;
              rx_sof     <= first_byte;
              first_byte <= 1'b0;
            end
            hold     <= rxd_reg;
            hold_vld <= 1'b1;
            crc      <= crc_byte(crc, rxd_reg);
            if (byte_cnt != LEN_SAT) byte_cnt <= byte_cnt + 11'd1;
            if (er_reg || byte_cnt >= MAX_L) sticky_err <= 1'b1;
          end else begin
            state    <= IDLE;
            hold_vld <= 1'b0;
            if (hold_vld) begin
              rx_valid   <= 1'b1;
              rx_data    <= hold;
              rx_sof     <= first_byte;
              rx_eof     <= 1'b1;
              first_byte <= 1'b0;
              rx_len     <= byte_cnt;
              rx_crc_ok  <= crc_match;
              rx_err     <= sticky_err || (byte_cnt < MIN_L) || !crc_match;
            end
          end
        end

        DROP: begin
          if (!dv_reg) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Self-checking bench for gmii_rx_frame: random frames compared against a
// frame-level reference model of the expected output beats and counters.
module tb_gmii_rx_frame;

  localparam int MAX_LEN = 1522;
  localparam int MIN_LEN = 64;

  logic        gmii_rx_clk = 1'b0;
  logic        rst;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err;
  logic [10:0] rx_len;
  logic [15:0] frame_cnt, err_cnt;

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  gmii_rx_frame #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .gmii_rx_clk(gmii_rx_clk), .rst(rst),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_crc_ok(rx_crc_ok), .rx_err(rx_err), .rx_len(rx_len),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        crc_ok;
    logic        err;
    logic [10:0] len;
  } beat_t;

  beat_t      mon_q[$];
  beat_t      exp_q[$];
  logic [7:0] frm[$];
  logic [7:0] raw[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_frames = 0;
  int         exp_errs = 0;

  always @(negedge gmii_rx_clk) begin
    if (rx_valid) begin
      beat_t b;
      b.data = rx_data; b.sof = rx_sof; b.eof = rx_eof;
      b.crc_ok = rx_crc_ok; b.err = rx_err; b.len = rx_len;
      mon_q.push_back(b);
    end
  end

  // Bit-serial reflected CRC-32, LSB of each byte first.
  function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge gmii_rx_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic e, input logic [7:0] d);
    gmii_rx_dv = v; gmii_rx_er = e; gmii_rxd = d;
    tick(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  // Random payload of n-4 bytes followed by its FCS, optionally with one bit flipped.
  task automatic build_frame(input int n, input int corrupt_at);
    logic [31:0] c;
    frm.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) begin
      frm.push_back(8'($urandom));
      c = crc_bits(c, frm[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    if (corrupt_at >= 0) frm[corrupt_at] = frm[corrupt_at] ^ 8'h01;
  endtask

  // Drives preamble, SFD and frm; appends the beats the frame must produce.
  task automatic send_frame(input int pre_len, input int er_at, input int gap);
    logic [31:0] c;
    int    n;
    logic  ok, err;
    beat_t b;
    for (int i = 0; i < pre_len; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < frm.size(); i++) drive(1'b1, i == er_at, frm[i]);
    idle(gap);
    n = frm.size();
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_bits(c, frm[i]);
    ok  = (c == 32'hDEBB_20E3);
    err = (er_at >= 0) || (n > MAX_LEN) || (n < MIN_LEN) || !ok;
    for (int i = 0; i < n; i++) begin
      b.data = frm[i]; b.sof = (i == 0); b.eof = (i == n - 1);
      b.crc_ok = ok; b.err = err; b.len = 11'((n > 2047) ? 2047 : n);
      exp_q.push_back(b);
    end
    exp_frames++;
    if (err) exp_errs++;
  endtask

  task automatic send_raw(input int gap);
    for (int i = 0; i < raw.size(); i++) drive(1'b1, 1'b0, raw[i]);
    idle(gap);
  endtask

  task automatic check_stream(input string name);
    int bad_flow, bad_end, first_bad, m;
    tick(6);
    n_cmp++;
    if (mon_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s beats: got %0d expected %0d", name, mon_q.size(), exp_q.size());
    end
    m = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    bad_flow = 0; bad_end = 0; first_bad = -1;
    for (int i = 0; i < m; i++) begin
      if (mon_q[i].data !== exp_q[i].data || mon_q[i].sof !== exp_q[i].sof ||
          mon_q[i].eof !== exp_q[i].eof) begin
        bad_flow++;
        if (first_bad < 0) first_bad = i;
      end
      if (exp_q[i].eof && (mon_q[i].len !== exp_q[i].len ||
          mon_q[i].crc_ok !== exp_q[i].crc_ok || mon_q[i].err !== exp_q[i].err)) begin
        bad_end++;
        $display("FAIL %s status@%0d: got len=%0d crc_ok=%b err=%b expected len=%0d crc_ok=%b err=%b",
                 name, i, mon_q[i].len, mon_q[i].crc_ok, mon_q[i].err,
                 exp_q[i].len, exp_q[i].crc_ok, exp_q[i].err);
      end
    end
    n_cmp++;
    if (bad_flow !== 0) begin
      n_bad++;
      $display("FAIL %s data: got %0d wrong beats (first at %0d) expected 0", name, bad_flow, first_bad);
    end
    n_cmp++;
    if (bad_end !== 0) n_bad++;
    n_cmp++;
    if (frame_cnt !== exp_frames[15:0]) begin
      n_bad++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", name, frame_cnt, exp_frames[15:0]);
    end
    n_cmp++;
    if (err_cnt !== exp_errs[15:0]) begin
      n_bad++;
      $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_errs[15:0]);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err} !== 5'b0 || rx_data !== 8'h00 ||
        rx_len !== 11'd0 || frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL %s: got valid=%b sof=%b eof=%b ok=%b err=%b data=%h len=%0d fc=%0d ec=%0d expected all 0",
               name, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_data, rx_len, frame_cnt, err_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    tick(3);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    tick(2);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_good();
    build_frame(64, -1);
    send_frame(7, -1, 1);
    check_stream("good64");
  endtask

  task automatic test_crc_bad();
    build_frame(64, 20);
    send_frame(7, -1, 1);
    check_stream("crc_bad");
  endtask

  task automatic test_bad_preamble();
    raw = '{8'h55, 8'h55, 8'h5D};
    for (int i = 0; i < 40; i++) raw.push_back(8'($urandom));
    send_raw(1);
    raw.delete();
    for (int i = 0; i < 8; i++) raw.push_back(8'h55);
    raw.push_back(8'hD5);
    for (int i = 0; i < 40; i++) raw.push_back(8'($urandom));
    send_raw(2);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b1, 8'hD5);
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 8'($urandom));
    idle(1);
    build_frame(70, -1);
    send_frame(7, -1, 1);
    check_stream("drop_then_good");
  endtask

  task automatic test_runt();
    build_frame(60, -1);
    send_frame(7, -1, 1);
    check_stream("runt60");
  endtask

  task automatic test_back_to_back();
    build_frame(1600, -1);
    send_frame(7, -1, 1);
    build_frame(64, -1);
    send_frame(7, -1, 1);
    check_stream("oversize_then_good");
  endtask

  task automatic test_rx_er();
    build_frame(80, -1);
    send_frame(7, 37, 1);
    build_frame(66, -1);
    send_frame(5, 65, 1);
    check_stream("rx_er");
  endtask

  task automatic test_mid_reset();
    build_frame(100, -1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, frm[i]);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rx_valid !== 1'b0 || rx_eof !== 1'b0 || frame_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b eof=%b frame_cnt=%0d expected 0/0/0", rx_valid, rx_eof, frame_cnt);
    end
    gmii_rx_dv = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    mon_q.delete();
    exp_q.delete();
    exp_frames = 0;
    exp_errs = 0;
    build_frame(64, -1);
    send_frame(7, -1, 1);
    check_stream("after_reset");
  endtask

  task automatic test_random();
    int n, corrupt, er_at;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(200, 60);
      corrupt = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
      er_at   = ($urandom_range(4, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
      build_frame(n, corrupt);
      send_frame($urandom_range(7, 1), er_at, $urandom_range(3, 1));
    end
    check_stream("random");
  endtask

  initial begin
    test_reset();
    test_good();
    test_crc_bad();
    test_bad_preamble();
    test_runt();
    test_back_to_back();
    test_rx_er();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
